// File: rtl/uart_alu_frame_if_if.sv
// Signal bundle between the frame interface (slave side) and its UART/ALU environment (master side).
// Strobe semantics: i_valid, o_alu_valid, o_tx_start, i_tx_done, o_timeout and o_overrun are single-cycle
// strobes with no backpressure; a byte is taken on any cycle i_valid is high and the block is not busy.
interface uart_alu_frame_if_if #(
  parameter int NB_DATA    = 8,
  parameter int NB_OPERAND = 16,
  parameter int NB_RESULT  = 16,
  parameter int NB_OP      = 6
);
  logic        [NB_DATA-1:0]    i_data;
  logic                         i_valid;
  logic        [NB_RESULT-1:0]  i_alu_result;
  logic                         i_tx_done;
  logic signed [NB_OPERAND-1:0] o_data_a;
  logic signed [NB_OPERAND-1:0] o_data_b;
  logic        [NB_OP-1:0]      o_operation;
  logic                         o_alu_valid;
  logic        [NB_DATA-1:0]    o_tx_data;
  logic                         o_tx_start;
  logic                         o_busy;
  logic                         o_timeout;
  logic                         o_overrun;
  logic        [2:0]            dbg_state;

  modport slave (
    input  i_data, i_valid, i_alu_result, i_tx_done,
    output o_data_a, o_data_b, o_operation, o_alu_valid, o_tx_data,
           o_tx_start, o_busy, o_timeout, o_overrun, dbg_state
  );

  modport master (
    output i_data, i_valid, i_alu_result, i_tx_done,
    input  o_data_a, o_data_b, o_operation, o_alu_valid, o_tx_data,
           o_tx_start, o_busy, o_timeout, o_overrun, dbg_state
  );
endinterface

// File: rtl/uart_alu_frame_if.sv
// Assembles MSB-first A/B/opcode frames from UART RX bytes, strobes the ALU, and
// serialises the captured result back out through the TX start/done handshake.
module uart_alu_frame_if #(
  parameter int NB_DATA    = 8,
  parameter int NB_OPERAND = 16,
  parameter int NB_RESULT  = 16,
  parameter int NB_OP      = 6,
  parameter int TIMEOUT    = 50000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  uart_alu_frame_if_if.slave    bus
);

  localparam int NBY_OP  = NB_OPERAND / NB_DATA;
  localparam int NBY_RES = NB_RESULT / NB_DATA;
  localparam int CW_OP   = $clog2(NBY_OP + 1);
  localparam int CW_RES  = $clog2(NBY_RES + 1);
  localparam int TW      = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    RX_A    = 3'd0,
    RX_B    = 3'd1,
    RX_OP   = 3'd2,
    EXEC    = 3'd3,
    TX_LOAD = 3'd4,
    TX_WAIT = 3'd5
  } state_t;

  state_t               state, state_nxt;
  logic [CW_OP-1:0]     rx_cnt;
  logic [CW_RES-1:0]    tx_cnt;
  logic [TW-1:0]        idle_cnt;
  logic [NB_RESULT-1:0] res_sr;

  logic rx_state, busy_state, in_frame, field_last, tx_last, timeout_hit;
  logic alu_valid_nxt, tx_start_nxt, timeout_nxt, overrun_nxt, busy_nxt;

  assign rx_state   = (state == RX_A) || (state == RX_B) || (state == RX_OP);
  assign busy_state = (state == EXEC) || (state == TX_LOAD) || (state == TX_WAIT);
  // A frame is "open" once any byte of it has landed; only open frames can time out.
  assign in_frame    = (state == RX_B) || (state == RX_OP) || (rx_cnt != '0);
  assign field_last  = (rx_cnt == CW_OP'(NBY_OP - 1));
  assign tx_last     = (tx_cnt == CW_RES'(NBY_RES - 1));
  assign timeout_hit = rx_state && in_frame && !bus.i_valid && (idle_cnt == TW'(TIMEOUT));
  assign bus.dbg_state = state;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= RX_A;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_A:    if (timeout_hit) state_nxt = RX_A;
               else if (bus.i_valid && field_last) state_nxt = RX_B;
      RX_B:    if (timeout_hit) state_nxt = RX_A;
               else if (bus.i_valid && field_last) state_nxt = RX_OP;
      RX_OP:   if (timeout_hit) state_nxt = RX_A;
               else if (bus.i_valid) state_nxt = EXEC;
      EXEC:    state_nxt = TX_LOAD;
      TX_LOAD: state_nxt = TX_WAIT;
      TX_WAIT: if (bus.i_tx_done) state_nxt = tx_last ? RX_A : TX_LOAD;
      default: state_nxt = RX_A;
    endcase
  end

  // Next values of the registered outputs; strobes are one cycle by construction.
  always_comb begin
    alu_valid_nxt = (state == RX_OP) && bus.i_valid;
    tx_start_nxt  = (state == TX_LOAD);
    timeout_nxt   = timeout_hit;
    overrun_nxt   = busy_state && bus.i_valid && !bus.o_overrun;
    busy_nxt      = (state_nxt == EXEC) || (state_nxt == TX_LOAD) || (state_nxt == TX_WAIT);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_cnt          <= '0;
      tx_cnt          <= '0;
      idle_cnt        <= '0;
      res_sr          <= '0;
      bus.o_data_a    <= '0;
      bus.o_data_b    <= '0;
      bus.o_operation <= '0;
      bus.o_alu_valid <= 1'b0;
      bus.o_tx_data   <= '0;
      bus.o_tx_start  <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_timeout   <= 1'b0;
      bus.o_overrun   <= 1'b0;
    end else begin
      bus.o_alu_valid <= alu_valid_nxt;
      bus.o_tx_start  <= tx_start_nxt;
      bus.o_timeout   <= timeout_nxt;
      bus.o_overrun   <= overrun_nxt;
      bus.o_busy      <= busy_nxt;

      if (timeout_hit || !rx_state || !in_frame || bus.i_valid) idle_cnt <= '0;
      else                                                       idle_cnt <= idle_cnt + TW'(1);

      if (timeout_hit)
        rx_cnt <= '0;
      else if (rx_state && bus.i_valid)
        rx_cnt <= ((state == RX_OP) || field_last) ? '0 : rx_cnt + CW_OP'(1);

      // Operands shift in MSB-first; the shift form also covers single-byte operands.
      if (bus.i_valid) begin
        case (state)
          RX_A:    bus.o_data_a    <= (bus.o_data_a << NB_DATA) | NB_OPERAND'(bus.i_data);
          RX_B:    bus.o_data_b    <= (bus.o_data_b << NB_DATA) | NB_OPERAND'(bus.i_data);
          RX_OP:   bus.o_operation <= bus.i_data[NB_OP-1:0];
          default: ;
        endcase
      end

      case (state)
        EXEC: begin
          res_sr <= bus.i_alu_result;
          tx_cnt <= '0;
        end
        TX_LOAD: bus.o_tx_data <= res_sr[NB_RESULT-1 -: NB_DATA];
        TX_WAIT: if (bus.i_tx_done && !tx_last) begin
          res_sr <= res_sr << NB_DATA;
          tx_cnt <= tx_cnt + CW_RES'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_alu_frame_if.md
Name: uart_alu_frame_if

Overview:
- Receives a byte stream from the UART RX path and assembles multi-byte frames: operand A, operand B, opcode.
- Presents the assembled frame to the ALU with a one-cycle valid strobe, then captures the ALU result.
- Serialises the result back to the UART TX path through a start/done handshake.
- Sits between uart_rx/uart_tx and the ALU. It generalises the single-byte operand interface to parametrised operand and result widths, and adds an inter-byte timeout and overrun detection.

Parameters:
- NB_DATA, 8, UART byte width.
- NB_OPERAND, 16, operand width. Must be an integer multiple of NB_DATA; bytes per operand NBY_OP = NB_OPERAND/NB_DATA.
- NB_RESULT, 16, ALU result width. Must be a multiple of NB_DATA; bytes per result NBY_RES = NB_RESULT/NB_DATA.
- NB_OP, 6, opcode width, with NB_OP <= NB_DATA. Taken from the low NB_OP bits of the opcode byte.
- TIMEOUT, 50000, maximum idle cycles allowed between bytes inside a partially received frame.

Ports:
- i_clock, input, 1, system clock.
- i_reset, input, 1, asynchronous, active-low reset.
- i_data, input, NB_DATA, received byte.
- i_valid, input, 1, one-cycle strobe marking i_data valid.
- i_alu_result, input, NB_RESULT, ALU result, combinational from o_data_a/o_data_b/o_operation.
- i_tx_done, input, 1, one-cycle strobe from the TX path when the current byte has been sent.
- o_data_a, output, NB_OPERAND, signed operand A.
- o_data_b, output, NB_OPERAND, signed operand B.
- o_operation, output, NB_OP, opcode.
- o_alu_valid, output, 1, one-cycle strobe when A/B/OP are complete.
- o_tx_data, output, NB_DATA, byte to transmit.
- o_tx_start, output, 1, one-cycle request to transmit o_tx_data.
- o_busy, output, 1, high from the cycle after the opcode byte until the last result byte is done.
- o_timeout, output, 1, one-cycle strobe when a partial frame is discarded.
- o_overrun, output, 1, one-cycle strobe when a byte arrives while busy.

Behaviour:
- Reset: i_reset low asynchronously forces state RX_A and clears byte and timeout counters. All outputs go to 0: o_data_a, o_data_b, o_operation, o_alu_valid, o_tx_data, o_tx_start, o_busy, o_timeout, o_overrun. A reset mid-frame or mid-transmit abandons the operation with no further strobes.
- Byte order is MSB-first for operands and results. Each accepted byte shifts into the target register: reg <= {reg[NB_OPERAND-NB_DATA-1:0], i_data}.
- RX_A: each i_valid shifts into o_data_a. After NBY_OP bytes, go to RX_B.
- RX_B: same for o_data_b. After NBY_OP bytes, go to RX_OP.
- RX_OP: on i_valid, o_operation <= i_data[NB_OP-1:0] and go to EXEC.
- EXEC: lasts one cycle.
  - o_alu_valid = 1; o_busy = 1.
  - Next cycle, latch i_alu_result into an internal shift register and go to TX_LOAD.
  - Latency: opcode strobe at cycle N gives o_alu_valid at N+1 and result latched at the N+2 edge.
- TX_LOAD: o_tx_data <= result MSB byte and pulse o_tx_start for one cycle, then go to TX_WAIT.
- TX_WAIT: on i_tx_done, if bytes sent < NBY_RES, shift the result and return to TX_LOAD. Otherwise go to RX_A and drop o_busy the same cycle.
- o_data_a, o_data_b and o_operation hold their values until overwritten by the next frame.
- Timeout:
  - The counter runs only in RX_A/RX_B/RX_OP while at least one byte of the current frame has been received.
  - It clears on every accepted byte.
  - When the count reaches TIMEOUT with no byte: o_timeout pulses, the state returns to RX_A, and the byte counter clears. Operand registers are not cleared.
  - An empty frame, with zero bytes received, never times out.
  - If i_valid arrives in the same cycle the count reaches TIMEOUT, the byte is accepted and no timeout occurs.
- Overrun: i_valid during EXEC/TX_LOAD/TX_WAIT drops the byte, pulses o_overrun and leaves state unaffected.
- i_tx_done outside TX_WAIT is ignored.
- Strobes (o_alu_valid, o_tx_start, o_timeout, o_overrun) are registered and never high for two consecutive cycles.

Test Plan:
- Basic ADD (defaults; bench ALU model is A+B when OP=6'b100000): bytes 0xFF,0xFE,0x00,0x05,0x20 → o_data_a=-2, o_data_b=5, o_operation=0x20, one o_alu_valid pulse; TX bytes 0x00 then 0x03, each emitted only after the previous i_tx_done; o_busy falls after the second done.
- Timeout: bytes 0x12,0x34,0x56, then idle TIMEOUT cycles → single o_timeout pulse, state back to RX_A. A following full frame 0x00,0x01,0x00,0x02,0x20 → result 0x0003.
- Overrun: during TX_WAIT, send i_valid with 0xAA → o_overrun pulse, TX completes normally, next frame is unaffected.
- Reset mid-transmit: assert i_reset low between the two TX bytes → all outputs 0 immediately. After release, no o_tx_start until a new full frame arrives.
- Boundary: i_valid coincident with timeout expiry → byte accepted, no o_timeout. Parametrised run with NB_OPERAND=8, NB_RESULT=8 → 3-byte frame, 1-byte response.
- Back-to-back: two frames with i_valid every 20 cycles and immediate i_tx_done → two o_alu_valid pulses and four TX bytes, in order.
